// File: rtl/ibex_pext_simd_exec.sv
// ----------------------------------------------------------------------------
// ibex_pext_simd_exec
// Multi-cycle packed-SIMD add/sub unit. The unit accepts one operation while
// idle, then processes one lane per cycle through a single shared 33-bit adder.
// It holds the packed result until the consumer acknowledges it.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   valid_i / ready_o         request handshake (ready_o high only when idle)
//   operand_a_i, operand_b_i  packed SIMD operands
//   width32_i, width8_i       lane width select (32 wins, neither = 16-bit)
//   signed_ops_i              signed lane arithmetic
//   alu_sub_i[1:0]            subtract per halfword (bit0 only for 8/32-bit)
//   mode_i[1:0]               00 wrap, 01 saturate, 10 halving, 11 wrap
//   valid_o, result_o         result handshake; result_o is 0 when not valid
//   result_ack_i              consumer takes the result
//   vxsat_clr_i, vxsat_o      sticky saturation flag and its clear
// ----------------------------------------------------------------------------
module ibex_pext_simd_exec #(
    parameter logic SatFlagEn = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        width32_i,
    input  logic        width8_i,
    input  logic        signed_ops_i,
    input  logic [1:0]  alu_sub_i,
    input  logic [1:0]  mode_i,
    output logic        valid_o,
    output logic [31:0] result_o,
    input  logic        result_ack_i,
    input  logic        vxsat_clr_i,
    output logic        vxsat_o
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned SUM_W = XLEN + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] LW8  = 2'd0;
    localparam logic [1:0] LW16 = 2'd1;
    localparam logic [1:0] LW32 = 2'd2;

    localparam logic [1:0] MODE_SAT  = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic            r_ready;
    logic            r_valid;
    logic            w_ready_nxt;
    logic            w_valid_nxt;

    logic            w_accept;
    logic            w_calc;
    logic            w_done_ack;
    logic            w_last;

    // ------------------------------------------------------------------
    // Captured operation and lane datapath
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [1:0]      r_lw;
    logic            r_signed;
    logic [1:0]      r_sub;
    logic [1:0]      r_mode;
    logic [1:0]      r_lane;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_result;

    logic [4:0]      w_shamt;
    logic            w_lane_sub;
    logic [XLEN-1:0] w_a_sh;
    logic [XLEN-1:0] w_b_sh;
    logic [SUM_W-1:0] w_a_ext;
    logic [SUM_W-1:0] w_b_ext;
    logic [SUM_W-1:0] w_sum;

    logic            w_top;
    logic            w_msb;
    logic [XLEN-1:0] w_wrap;
    logic [XLEN-1:0] w_half;
    logic [XLEN-1:0] w_ones;
    logic [XLEN-1:0] w_maxpos;
    logic [XLEN-1:0] w_minneg;
    logic            w_ovf;
    logic [XLEN-1:0] w_satval;
    logic [XLEN-1:0] w_lane_res;
    logic            w_lane_ovf;
    logic [XLEN-1:0] w_acc_nxt;

    assign w_accept   = (r_state == IDLE) & valid_i;
    assign w_calc     = (r_state == CALC);
    assign w_done_ack = (r_state == DONE) & result_ack_i;

    // State register plus registered handshake outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= w_ready_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt = r_state;
        w_ready_nxt = r_ready;
        w_valid_nxt = r_valid;
        case (r_state)
            IDLE: begin
                if (valid_i) begin
                    w_state_nxt = CALC;
                    w_ready_nxt = 1'b0;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                    w_valid_nxt = 1'b1;
                end
            end
            DONE: begin
                if (result_ack_i) begin
                    w_state_nxt = IDLE;
                    w_ready_nxt = 1'b1;
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_ready_nxt = 1'b1;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    // Lane position, last-lane detect and per-lane subtract select
    always_comb begin
        w_shamt    = 5'd0;
        w_last     = 1'b1;
        w_lane_sub = r_sub[0];
        case (r_lw)
            LW8: begin
                w_shamt = {r_lane, 3'b000};
                w_last  = (r_lane == 2'd3);
            end
            LW16: begin
                w_shamt    = {r_lane[0], 4'b0000};
                w_last     = r_lane[0];
                w_lane_sub = r_lane[0] ? r_sub[1] : r_sub[0];
            end
            default: begin
                w_shamt = 5'd0;
                w_last  = 1'b1;
            end
        endcase
    end

    assign w_a_sh = r_a >> w_shamt;
    assign w_b_sh = r_b >> w_shamt;

    // Extend the current lane to 33 bits so one adder serves every width
    always_comb begin
        w_a_ext = '0;
        w_b_ext = '0;
        case (r_lw)
            LW8: begin
                w_a_ext = {{25{r_signed & w_a_sh[7]}}, w_a_sh[7:0]};
                w_b_ext = {{25{r_signed & w_b_sh[7]}}, w_b_sh[7:0]};
            end
            LW16: begin
                w_a_ext = {{17{r_signed & w_a_sh[15]}}, w_a_sh[15:0]};
                w_b_ext = {{17{r_signed & w_b_sh[15]}}, w_b_sh[15:0]};
            end
            default: begin
                w_a_ext = {r_signed & w_a_sh[31], w_a_sh};
                w_b_ext = {r_signed & w_b_sh[31], w_b_sh};
            end
        endcase
    end

    // Shared adder; subtraction as a + ~b + 1
    assign w_sum = w_a_ext + (w_b_ext ^ {SUM_W{w_lane_sub}}) + SUM_W'(w_lane_sub);

    // Pick the width-dependent views of the W+1-bit lane result
    always_comb begin
        w_top  = w_sum[32];
        w_msb  = w_sum[31];
        w_wrap = w_sum[31:0];
        w_half = w_sum[32:1];
        w_ones = 32'hFFFF_FFFF;
        case (r_lw)
            LW8: begin
                w_top  = w_sum[8];
                w_msb  = w_sum[7];
                w_wrap = XLEN'(w_sum[7:0]);
                w_half = XLEN'(w_sum[8:1]);
                w_ones = 32'h0000_00FF;
            end
            LW16: begin
                w_top  = w_sum[16];
                w_msb  = w_sum[15];
                w_wrap = XLEN'(w_sum[15:0]);
                w_half = XLEN'(w_sum[16:1]);
                w_ones = 32'h0000_FFFF;
            end
            default: begin
                w_top  = w_sum[32];
                w_msb  = w_sum[31];
                w_wrap = w_sum[31:0];
                w_half = w_sum[32:1];
                w_ones = 32'hFFFF_FFFF;
            end
        endcase
    end

    assign w_maxpos = w_ones >> 1;
    assign w_minneg = w_ones & ~w_maxpos;

    // Signed: bit W is the true sign, overflow when it differs from bit W-1.
    // Unsigned: bit W is the carry (add) or the borrow (sub).
    assign w_ovf    = r_signed ? (w_top ^ w_msb) : w_top;
    assign w_satval = r_signed ? (w_top ? w_minneg : w_maxpos)
                               : (w_lane_sub ? '0 : w_ones);

    // Mode select for the current lane
    always_comb begin
        w_lane_res = w_wrap;
        w_lane_ovf = 1'b0;
        case (r_mode)
            MODE_SAT: begin
                w_lane_res = w_ovf ? w_satval : w_wrap;
                w_lane_ovf = w_ovf;
            end
            MODE_HALF: begin
                w_lane_res = w_half;
            end
            default: begin
                w_lane_res = w_wrap;
            end
        endcase
    end

    // Lanes arrive in order into a cleared accumulator, so OR-insert suffices
    assign w_acc_nxt = r_acc | (w_lane_res << w_shamt);

    // Operation capture, lane sequencing and result register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a      <= '0;
            r_b      <= '0;
            r_lw     <= LW16;
            r_signed <= 1'b0;
            r_sub    <= '0;
            r_mode   <= '0;
            r_lane   <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_a      <= operand_a_i;
                r_b      <= operand_b_i;
                r_lw     <= width32_i ? LW32 : (width8_i ? LW8 : LW16);
                r_signed <= signed_ops_i;
                r_sub    <= alu_sub_i;
                r_mode   <= mode_i;
                r_lane   <= '0;
                r_acc    <= '0;
            end else if (w_calc) begin
                r_lane <= r_lane + 2'd1;
                r_acc  <= w_acc_nxt;
                if (w_last) begin
                    r_result <= w_acc_nxt;
                end
            end
            if (w_done_ack) begin
                r_result <= '0;
            end
        end
    end

    assign ready_o  = r_ready;
    assign valid_o  = r_valid;
    assign result_o = r_result;

    // Sticky saturation flag; a set in the same cycle as a clear wins
    if (SatFlagEn) begin : g_sat
        logic r_ovf;
        logic r_vxsat;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_ovf   <= 1'b0;
                r_vxsat <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_ovf <= 1'b0;
                end else if (w_calc) begin
                    r_ovf <= r_ovf | w_lane_ovf;
                end
                r_vxsat <= (r_vxsat & ~vxsat_clr_i) | (w_done_ack & r_ovf);
            end
        end

        assign vxsat_o = r_vxsat;
    end else begin : g_nosat
        logic w_unused_sat;
        assign w_unused_sat = ^{w_lane_ovf, vxsat_clr_i};
        assign vxsat_o      = 1'b0;
    end

endmodule

// File: tb/tb_ibex_pext_simd_exec.sv
module tb_ibex_pext_simd_exec;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        width32_i;
    logic        width8_i;
    logic        signed_ops_i;
    logic [1:0]  alu_sub_i;
    logic [1:0]  mode_i;
    logic        valid_o;
    logic [31:0] result_o;
    logic        result_ack_i;
    logic        vxsat_clr_i;
    logic        vxsat_o;

    int   total;
    int   bad;
    logic exp_vx;

    ibex_pext_simd_exec dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .operand_a_i  (operand_a_i),
        .operand_b_i  (operand_b_i),
        .width32_i    (width32_i),
        .width8_i     (width8_i),
        .signed_ops_i (signed_ops_i),
        .alu_sub_i    (alu_sub_i),
        .mode_i       (mode_i),
        .valid_o      (valid_o),
        .result_o     (result_o),
        .result_ack_i (result_ack_i),
        .vxsat_clr_i  (vxsat_clr_i),
        .vxsat_o      (vxsat_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: each lane as an integer sum, then wrap / clamp / floor-halve
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic w32, input logic w8, input logic sg,
                                          input logic [1:0] sub, input logic [1:0] mode);
        int w;
        int n;
        longint one, mask, av, bv, r, lo, hi, res;
        logic [31:0] out;
        logic ovf;
        logic s;
        w    = w32 ? 32 : (w8 ? 8 : 16);
        n    = 32 / w;
        one  = 1;
        mask = (one << w) - one;
        out  = '0;
        ovf  = 1'b0;
        for (int i = 0; i < n; i++) begin
            av = longint'({32'd0, a >> (i * w)}) & mask;
            bv = longint'({32'd0, b >> (i * w)}) & mask;
            if (sg && av >= (one << (w - 1))) av = av - (one << w);
            if (sg && bv >= (one << (w - 1))) bv = bv - (one << w);
            s = (w == 16 && i == 1) ? sub[1] : sub[0];
            r = s ? av - bv : av + bv;
            if (sg) begin
                lo = -(one << (w - 1));
                hi = (one << (w - 1)) - one;
            end else begin
                lo = 0;
                hi = mask;
            end
            if (mode == 2'b01) begin
                if (r > hi) begin
                    res = hi;
                    ovf = 1'b1;
                end else if (r < lo) begin
                    res = lo;
                    ovf = 1'b1;
                end else begin
                    res = r;
                end
            end else if (mode == 2'b10) begin
                res = r >>> 1;
            end else begin
                res = r;
            end
            out = out | (32'(res & mask) << (i * w));
        end
        return {ovf, out};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic w32, input logic w8, input logic sg,
                          input logic [1:0] sub, input logic [1:0] mode,
                          input logic [31:0] exp_res, input logic exp_ovf,
                          input int ack_delay, input logic clr_at_ack);
        int n;
        int lanes;
        lanes = w32 ? 1 : (w8 ? 4 : 2);
        @(negedge clk);
        check({tag, ":ready_idle"}, 33'(ready_o), 33'(1'b1));
        operand_a_i  = a;
        operand_b_i  = b;
        width32_i    = w32;
        width8_i     = w8;
        signed_ops_i = sg;
        alu_sub_i    = sub;
        mode_i       = mode;
        valid_i      = 1'b1;
        @(negedge clk);
        valid_i      = 1'b0;
        operand_a_i  = $urandom;
        operand_b_i  = $urandom;
        width32_i    = 1'($urandom);
        width8_i     = 1'($urandom);
        signed_ops_i = 1'($urandom);
        alu_sub_i    = 2'($urandom);
        mode_i       = 2'($urandom);
        n = 1;
        while (valid_o !== 1'b1 && n < 12) begin
            check({tag, ":busy_result_zero"}, 33'(result_o), 33'd0);
            check({tag, ":busy_not_ready"}, 33'(ready_o), 33'd0);
            @(negedge clk);
            n++;
        end
        check({tag, ":latency"}, 33'(n), 33'(lanes + 1));
        check({tag, ":result"}, 33'(result_o), 33'(exp_res));
        check({tag, ":done_not_ready"}, 33'(ready_o), 33'd0);
        check({tag, ":vxsat_before_ack"}, 33'(vxsat_o), 33'(exp_vx));
        for (int k = 0; k < ack_delay; k++) begin
            @(negedge clk);
            check({tag, ":hold_result"}, 33'(result_o), 33'(exp_res));
            check({tag, ":hold_valid"}, 33'(valid_o), 33'(1'b1));
            check({tag, ":hold_not_ready"}, 33'(ready_o), 33'd0);
        end
        result_ack_i = 1'b1;
        vxsat_clr_i  = clr_at_ack;
        @(negedge clk);
        result_ack_i = 1'b0;
        vxsat_clr_i  = 1'b0;
        exp_vx = (exp_vx & ~clr_at_ack) | exp_ovf;
        check({tag, ":valid_low_after_ack"}, 33'(valid_o), 33'd0);
        check({tag, ":result_zero_after_ack"}, 33'(result_o), 33'd0);
        check({tag, ":ready_after_ack"}, 33'(ready_o), 33'(1'b1));
        check({tag, ":vxsat_after_ack"}, 33'(vxsat_o), 33'(exp_vx));
    endtask

    task automatic clear_vxsat();
        @(negedge clk);
        vxsat_clr_i = 1'b1;
        @(negedge clk);
        vxsat_clr_i = 1'b0;
        exp_vx = 1'b0;
        check("vxsat_clear", 33'(vxsat_o), 33'd0);
    endtask

    initial begin
        logic [32:0] m;
        logic [31:0] ra, rb;
        logic        rw32, rw8, rsg;
        logic [1:0]  rsub, rmode;
        logic        seen_valid;

        total        = 0;
        bad          = 0;
        exp_vx       = 1'b0;
        rst_n        = 1'b0;
        valid_i      = 1'b0;
        operand_a_i  = '0;
        operand_b_i  = '0;
        width32_i    = 1'b0;
        width8_i     = 1'b0;
        signed_ops_i = 1'b0;
        alu_sub_i    = '0;
        mode_i       = '0;
        result_ack_i = 1'b0;
        vxsat_clr_i  = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 33'(ready_o), 33'(1'b1));
        check("rst_valid", 33'(valid_o), 33'd0);
        check("rst_result", 33'(result_o), 33'd0);
        check("rst_vxsat", 33'(vxsat_o), 33'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 33'(ready_o), 33'(1'b1));

        // Signed 8-bit saturating add
        run_op("s8_sat_add", 32'h7F7F0180, 32'h01FF0180, 1'b0, 1'b1, 1'b1, 2'b00, 2'b01,
               32'h7F7E0280, 1'b1, 0, 1'b0);
        // Signed 16-bit wrap, lower lane subtracts; flag stays set
        run_op("s16_wrap", 32'h00010005, 32'h00020007, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00,
               32'h0003FFFE, 1'b0, 0, 1'b0);
        clear_vxsat();
        // Unsigned 32-bit halving subtract
        run_op("u32_half_sub", 32'h00000000, 32'h00000002, 1'b1, 1'b0, 1'b0, 2'b01, 2'b10,
               32'hFFFFFFFF, 1'b0, 0, 1'b0);
        // Unsigned 16-bit saturating subtract, ack held off 3 cycles, clear with set
        run_op("u16_sat_sub", 32'h00050010, 32'h00060001, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01,
               32'h0000000F, 1'b1, 3, 1'b1);
        // Both width selects set: 32-bit lanes, signed saturation at max positive
        run_op("both_w_s32_sat", 32'h7FFFFFFF, 32'h00000001, 1'b1, 1'b1, 1'b1, 2'b00, 2'b01,
               32'h7FFFFFFF, 1'b1, 1, 1'b0);
        clear_vxsat();
        // Mode 11 behaves as wrap and never touches the flag
        run_op("u8_mode11", 32'hFFFF0102, 32'h01FF0304, 1'b0, 1'b1, 1'b0, 2'b00, 2'b11,
               32'h00FE0406, 1'b0, 0, 1'b0);

        // Randomized operations against the reference model
        for (int t = 0; t < 40; t++) begin
            ra    = ($urandom_range(0, 3) == 0) ? 32'h7F80FF00 : $urandom;
            rb    = ($urandom_range(0, 3) == 0) ? 32'h807FFF01 : $urandom;
            rw32  = ($urandom_range(0, 3) == 0);
            rw8   = 1'($urandom);
            rsg   = 1'($urandom);
            rsub  = 2'($urandom);
            rmode = 2'($urandom);
            m = model(ra, rb, rw32, rw8, rsg, rsub, rmode);
            run_op("rand", ra, rb, rw32, rw8, rsg, rsub, rmode, m[31:0], m[32],
                   $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
        end

        // Make the flag visible, then reset in the 2nd CALC cycle of an 8-bit op
        run_op("pre_rst_sat", 32'h7F7F7F7F, 32'h01010101, 1'b0, 1'b1, 1'b1, 2'b00, 2'b01,
               32'h7F7F7F7F, 1'b1, 0, 1'b0);
        @(negedge clk);
        operand_a_i  = 32'h7F7F7F7F;
        operand_b_i  = 32'h01010101;
        width32_i    = 1'b0;
        width8_i     = 1'b1;
        signed_ops_i = 1'b1;
        alu_sub_i    = 2'b00;
        mode_i       = 2'b01;
        valid_i      = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        exp_vx = 1'b0;
        check("midrst_ready", 33'(ready_o), 33'(1'b1));
        check("midrst_valid", 33'(valid_o), 33'd0);
        check("midrst_result", 33'(result_o), 33'd0);
        check("midrst_vxsat", 33'(vxsat_o), 33'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            seen_valid = seen_valid | valid_o;
        end
        check("midrst_no_valid", 33'(seen_valid), 33'd0);
        check("midrst_ready_after", 33'(ready_o), 33'(1'b1));
        check("midrst_vxsat_after", 33'(vxsat_o), 33'd0);

        // Recovery after reset
        m = model(32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);
        run_op("post_rst_op", 32'h12345678, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00,
               m[31:0], m[32], 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
